mor1kx_branch_resolver: RTL and testbench
=========================================

// Module: mor1kx_branch_resolver
// PURPOSE
//  Resolution end of static branch prediction. Captures each l.bf/l.bnf as it
//  leaves decode, together with the predicted flag, PC and taken target.
//  Holds it until execute produces the real flag, then compares the two.
//  On a mismatch, pulses a mispredict with the correct fetch redirect PC.
//  Sits between decode (predictor output) and execute/ctrl (flag source, fetch redirect).
// PARAMETERS
//  OPTION_OPERAND_WIDTH  32  PC / target width
//  STAT_WIDTH            16  width of saturating statistics counters
// PORTS
//  clk                    in   1     clock
//  rst                    in   1     synchronous active-high reset
//  padv_decode_i          in   1     decode advances; branch in decode is handed on
//  decode_op_bf_i         in   1     decode insn is l.bf
//  decode_op_bnf_i        in   1     decode insn is l.bnf
//  predicted_flag_i       in   1     predictor result for the decode branch
//  decode_pc_i            in   OW    PC of the decode branch
//  decode_branch_target_i in   OW    taken target of the decode branch
//  execute_flag_valid_i   in   1     SR[F] for the pending branch is final this cycle
//  execute_flag_i         in   1     SR[F] value
//  pipeline_flush_i       in   1     exception/flush; discards the pending branch
//  pending_o              out  1     a captured branch awaits resolution
//  stall_decode_o         out  1     decode must hold; branch slot occupied
//  mispredict_o           out  1     one-cycle pulse: prediction was wrong
//  redirect_pc_o          out  OW    correct fetch PC; valid while mispredict_o=1
//  resolved_taken_o       out  1     actual direction of the last resolved branch
//  branch_count_o         out  SW    resolved branches, saturating
//  mispredict_count_o     out  SW    mispredicted branches, saturating
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0, including counters and redirect_pc_o.
//  - is_br = decode_op_bf_i | decode_op_bnf_i. If both are set, the insn is treated as bf.
//  - resolve = PENDING & execute_flag_valid_i.
//  - capture = padv_decode_i & is_br & !stall_decode_o.
//    capture registers pred, bf-ness, pc and target.
//  - stall_decode_o: combinational; = PENDING & !resolve & is_br.
//  - FSM:
//    - IDLE: capture -> PENDING. execute_flag_valid_i is ignored in IDLE.
//    - PENDING: resolve & !capture -> IDLE.
//      resolve & capture -> stays PENDING with the new branch.
//      This is a back-to-back branch with no stall.
//  - Resolution (in the resolve cycle):
//    - taken = bf ? execute_flag_i : !execute_flag_i.
//    - mis = taken != pred.
//  - The next cycle registers:
//    - mispredict_o = mis for exactly 1 cycle.
//    - redirect_pc_o = taken ? target : pc + 8 (skips the delay slot); width wraps mod 2^OW.
//    - resolved_taken_o = taken. It holds until the next resolution.
//    - Latency from resolve to mispredict_o is 1 cycle.
//  - Counters: on resolve, branch_count_o += 1; if mis, mispredict_count_o += 1.
//    Both stick at all-ones (no wrap). Flushed branches are not counted.
//  - pipeline_flush_i has top priority:
//    - Next state is IDLE.
//    - No capture and no resolution that cycle.
//    - A mispredict_o already registered this cycle still completes its 1-cycle pulse.
//  - rst mid-operation behaves as a flush and also zeroes the counters.
//  - pending_o = (state == PENDING); registered.
// TESTING
//  1. bf pred=1, pc=0x100, tgt=0x80; flag_valid with flag=1.
//     -> no mispredict_o; branch_count=1, mispredict_count=0; resolved_taken_o=1.
//  2. bnf pred=1, pc=0x100; flag=1 (not taken).
//     -> mispredict_o 1 cycle after resolve, redirect_pc_o=0x108; mispredict_count=1.
//  3. bf pred=0, tgt=0x200; flag=1.
//     -> mispredict_o pulse, redirect_pc_o=0x200, resolved_taken_o=1.
//  4. Second branch in decode while PENDING and flag_valid=0 -> stall_decode_o=1.
//     Assert flag_valid that cycle -> stall_decode_o=0, new branch captured, pending_o stays 1.
//  5. PENDING then pipeline_flush_i=1 -> pending_o=0 next cycle.
//     A later flag_valid gives no mispredict_o, and the counters are unchanged.
//  6. STAT_WIDTH=4, 20 consecutive mispredicted branches
//     -> both counters read 15; rst=1 returns them to 0.

Source files
------------

// File: rtl/mor1kx_branch_resolver.sv
// Static-prediction resolver: holds one l.bf/l.bnf from decode until execute
// delivers SR[F], then flags a mispredict with the corrected fetch PC.
module mor1kx_branch_resolver #(
   parameter int OPTION_OPERAND_WIDTH = 32,
   parameter int STAT_WIDTH           = 16
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            padv_decode_i,
   input  logic                            decode_op_bf_i,
   input  logic                            decode_op_bnf_i,
   input  logic                            predicted_flag_i,
   input  logic [OPTION_OPERAND_WIDTH-1:0] decode_pc_i,
   input  logic [OPTION_OPERAND_WIDTH-1:0] decode_branch_target_i,
   input  logic                            execute_flag_valid_i,
   input  logic                            execute_flag_i,
   input  logic                            pipeline_flush_i,
   output logic                            pending_o,
   output logic                            stall_decode_o,
   output logic                            mispredict_o,
   output logic [OPTION_OPERAND_WIDTH-1:0] redirect_pc_o,
   output logic                            resolved_taken_o,
   output logic [STAT_WIDTH-1:0]           branch_count_o,
   output logic [STAT_WIDTH-1:0]           mispredict_count_o
);

   typedef enum logic {IDLE, PENDING} state_t;

   state_t                            state_q;
   logic                              pred_q;
   logic                              bf_q;
   logic [OPTION_OPERAND_WIDTH-1:0]   pc_q;
   logic [OPTION_OPERAND_WIDTH-1:0]   tgt_q;
   logic                              mispredict_q;
   logic [OPTION_OPERAND_WIDTH-1:0]   redirect_q;
   logic                              taken_q;
   logic [STAT_WIDTH-1:0]             bcnt_q;
   logic [STAT_WIDTH-1:0]             mcnt_q;

   logic is_br, resolve, res_ok, stall, capture, taken, mis;

   assign is_br   = decode_op_bf_i | decode_op_bnf_i;
   assign resolve = (state_q == PENDING) & execute_flag_valid_i;
   assign stall   = (state_q == PENDING) & ~resolve & is_br;
   // A flush kills both the hand-off from decode and the resolution in flight.
   assign capture = padv_decode_i & is_br & ~stall & ~pipeline_flush_i;
   assign res_ok  = resolve & ~pipeline_flush_i;
   assign taken   = bf_q ? execute_flag_i : ~execute_flag_i;
   assign mis     = taken ^ pred_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         pred_q       <= 1'b0;
         bf_q         <= 1'b0;
         pc_q         <= '0;
         tgt_q        <= '0;
         mispredict_q <= 1'b0;
         redirect_q   <= '0;
         taken_q      <= 1'b0;
         bcnt_q       <= '0;
         mcnt_q       <= '0;
      end else begin
         mispredict_q <= res_ok & mis;
         if (res_ok) begin
            // Not-taken falls through past the delay slot.
            redirect_q <= taken ? tgt_q : pc_q + OPTION_OPERAND_WIDTH'(8);
            taken_q    <= taken;
            if (bcnt_q != '1)
               bcnt_q <= bcnt_q + 1'b1;
            if (mis && mcnt_q != '1)
               mcnt_q <= mcnt_q + 1'b1;
         end
         if (capture) begin
            pred_q <= predicted_flag_i;
            bf_q   <= decode_op_bf_i;
            pc_q   <= decode_pc_i;
            tgt_q  <= decode_branch_target_i;
         end
         if (pipeline_flush_i)
            state_q <= IDLE;
         else begin
            case (state_q)
               IDLE:    if (capture) state_q <= PENDING;
               PENDING: if (res_ok && !capture) state_q <= IDLE;
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign pending_o          = (state_q == PENDING);
   assign stall_decode_o     = stall;
   assign mispredict_o       = mispredict_q;
   assign redirect_pc_o      = redirect_q;
   assign resolved_taken_o   = taken_q;
   assign branch_count_o     = bcnt_q;
   assign mispredict_count_o = mcnt_q;

endmodule

// File: tb/tb_mor1kx_branch_resolver.sv
// Bench for mor1kx_branch_resolver: directed scenarios plus a randomized run
// against a transaction-level model of one outstanding branch.
module tb_mor1kx_branch_resolver;
   localparam int OW = 32;
   localparam int SW = 4;
   localparam int SMAX = (1 << SW) - 1;

   logic clk = 1'b0;
   logic rst, padv, op_bf, op_bnf, pred, fv, flag, flush;
   logic [OW-1:0] pc, tgt;
   logic pending, stall, mispredict, rtaken;
   logic [OW-1:0] redirect;
   logic [SW-1:0] bcnt, mcnt;

   int errors = 0;
   int checks = 0;

   // model: one optional outstanding branch record and the expected outputs
   bit m_pend, m_bf, m_pred;
   bit [OW-1:0] m_pc, m_tgt;
   bit e_mis, e_rt;
   bit [OW-1:0] e_red;
   int e_bc, e_mc;

   always #5 clk = ~clk;

   mor1kx_branch_resolver #(.OPTION_OPERAND_WIDTH(OW), .STAT_WIDTH(SW)) dut (
      .clk(clk), .rst(rst), .padv_decode_i(padv), .decode_op_bf_i(op_bf),
      .decode_op_bnf_i(op_bnf), .predicted_flag_i(pred), .decode_pc_i(pc),
      .decode_branch_target_i(tgt), .execute_flag_valid_i(fv),
      .execute_flag_i(flag), .pipeline_flush_i(flush), .pending_o(pending),
      .stall_decode_o(stall), .mispredict_o(mispredict), .redirect_pc_o(redirect),
      .resolved_taken_o(rtaken), .branch_count_o(bcnt), .mispredict_count_o(mcnt));

   function automatic bit exp_stall();
      return m_pend && !fv && (op_bf || op_bnf);
   endfunction

   task automatic idle_inputs();
      rst = 0; padv = 0; op_bf = 0; op_bnf = 0; pred = 0; fv = 0; flag = 0;
      flush = 0; pc = '0; tgt = '0;
   endtask

   task automatic set_br(input bit bf, input bit p, input bit [OW-1:0] a, input bit [OW-1:0] t);
      padv = 1; op_bf = bf; op_bnf = !bf; pred = p; pc = a; tgt = t;
   endtask

   // Advance one clock, evolving the model from the inputs of this cycle.
   task automatic tick();
      bit isbr, res, cap, tk;
      isbr = op_bf || op_bnf;
      res  = m_pend && fv && !flush;
      cap  = padv && isbr && !exp_stall() && !flush;
      if (rst) begin
         m_pend = 0; e_mis = 0; e_rt = 0; e_red = '0; e_bc = 0; e_mc = 0;
      end else begin
         e_mis = 0;
         if (res) begin
            tk = m_bf ? flag : !flag;
            e_mis = (tk != m_pred);
            e_rt  = tk;
            e_red = tk ? m_tgt : m_pc + 8;
            if (e_bc < SMAX) e_bc++;
            if (e_mis && e_mc < SMAX) e_mc++;
         end
         if (cap) begin
            m_bf = op_bf; m_pred = pred; m_pc = pc; m_tgt = tgt;
         end
         m_pend = flush ? 0 : (cap ? 1 : (res ? 0 : m_pend));
      end
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      idle_inputs(); rst = 1; tick(); rst = 0;
   endtask

   task automatic test_reset();
      idle_inputs(); rst = 1; fv = 1; flag = 1; tick(); tick(); rst = 0; fv = 0; flag = 0;
      checks++; if (pending !== 0) begin errors++; $display("FAIL reset_pending got=%0b exp=0", pending); end
      checks++; if (mispredict !== 0) begin errors++; $display("FAIL reset_mis got=%0b exp=0", mispredict); end
      checks++; if (redirect !== 0) begin errors++; $display("FAIL reset_redirect got=%0h exp=0", redirect); end
      checks++; if (rtaken !== 0) begin errors++; $display("FAIL reset_taken got=%0b exp=0", rtaken); end
      checks++; if (bcnt !== 0 || mcnt !== 0) begin errors++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", bcnt, mcnt); end
      checks++; if (stall !== 0) begin errors++; $display("FAIL reset_stall got=%0b exp=0", stall); end
   endtask

   task automatic test_correct_predict();
      do_reset();
      set_br(1, 1, 32'h100, 32'h80); tick(); idle_inputs();
      checks++; if (pending !== 1) begin errors++; $display("FAIL t1_pending got=%0b exp=1", pending); end
      fv = 1; flag = 1; tick(); idle_inputs();
      checks++; if (mispredict !== 0) begin errors++; $display("FAIL t1_mis got=%0b exp=0", mispredict); end
      checks++; if (bcnt !== 1 || mcnt !== 0) begin errors++; $display("FAIL t1_counts got=%0d/%0d exp=1/0", bcnt, mcnt); end
      checks++; if (rtaken !== 1) begin errors++; $display("FAIL t1_taken got=%0b exp=1", rtaken); end
      checks++; if (pending !== 0) begin errors++; $display("FAIL t1_idle got=%0b exp=0", pending); end
   endtask

   task automatic test_bnf_mispredict();
      set_br(0, 1, 32'h100, 32'h40); tick(); idle_inputs();
      fv = 1; flag = 1; tick(); idle_inputs();
      checks++; if (mispredict !== 1) begin errors++; $display("FAIL t2_mis got=%0b exp=1", mispredict); end
      checks++; if (redirect !== 32'h108) begin errors++; $display("FAIL t2_redirect got=%0h exp=108", redirect); end
      checks++; if (mcnt !== 1 || bcnt !== 2) begin errors++; $display("FAIL t2_counts got=%0d/%0d exp=2/1", bcnt, mcnt); end
      checks++; if (rtaken !== 0) begin errors++; $display("FAIL t2_taken got=%0b exp=0", rtaken); end
      tick();
      checks++; if (mispredict !== 0) begin errors++; $display("FAIL t2_pulse got=%0b exp=0", mispredict); end
   endtask

   task automatic test_bf_mispredict();
      set_br(1, 0, 32'h180, 32'h200); tick(); idle_inputs();
      fv = 1; flag = 1; tick(); idle_inputs();
      checks++; if (mispredict !== 1) begin errors++; $display("FAIL t3_mis got=%0b exp=1", mispredict); end
      checks++; if (redirect !== 32'h200) begin errors++; $display("FAIL t3_redirect got=%0h exp=200", redirect); end
      checks++; if (rtaken !== 1) begin errors++; $display("FAIL t3_taken got=%0b exp=1", rtaken); end
   endtask

   task automatic test_pc_wrap();
      do_reset();
      set_br(1, 1, 32'hFFFF_FFFC, 32'h10); tick(); idle_inputs();
      fv = 1; flag = 0; tick(); idle_inputs();
      checks++; if (mispredict !== 1 || redirect !== 32'h4) begin errors++; $display("FAIL wrap got=%0b/%0h exp=1/4", mispredict, redirect); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      set_br(1, 1, 32'h200, 32'h280); tick();
      set_br(0, 0, 32'h300, 32'h340); #1;
      checks++; if (stall !== 1) begin errors++; $display("FAIL b2b_stall got=%0b exp=1", stall); end
      tick();
      checks++; if (pending !== 1 || bcnt !== 0) begin errors++; $display("FAIL b2b_hold got=%0b/%0d exp=1/0", pending, bcnt); end
      fv = 1; flag = 1; #1;
      checks++; if (stall !== 0) begin errors++; $display("FAIL b2b_nostall got=%0b exp=0", stall); end
      tick(); idle_inputs();
      checks++; if (pending !== 1 || mispredict !== 0 || bcnt !== 1) begin errors++; $display("FAIL b2b_first got=%0b/%0b/%0d exp=1/0/1", pending, mispredict, bcnt); end
      fv = 1; flag = 0; tick(); idle_inputs();
      checks++; if (mispredict !== 1 || redirect !== 32'h340) begin errors++; $display("FAIL b2b_second got=%0b/%0h exp=1/340", mispredict, redirect); end
   endtask

   task automatic test_flush();
      bit [SW-1:0] b0, m0;
      b0 = bcnt; m0 = mcnt;
      set_br(1, 0, 32'h400, 32'h500); tick(); idle_inputs();
      flush = 1; fv = 1; flag = 1; tick(); idle_inputs();
      checks++; if (pending !== 0 || mispredict !== 0) begin errors++; $display("FAIL flush_state got=%0b/%0b exp=0/0", pending, mispredict); end
      fv = 1; flag = 1; tick(); idle_inputs();
      checks++; if (mispredict !== 0) begin errors++; $display("FAIL flush_late_mis got=%0b exp=0", mispredict); end
      checks++; if (bcnt !== b0 || mcnt !== m0) begin errors++; $display("FAIL flush_counts got=%0d/%0d exp=%0d/%0d", bcnt, mcnt, b0, m0); end
   endtask

   task automatic test_saturation();
      do_reset();
      set_br(1, 0, 32'h600, 32'h700); tick();
      for (int i = 0; i < 20; i++) begin
         fv = 1; flag = 1;
         if (i == 19) begin padv = 0; op_bf = 0; op_bnf = 0; end
         tick();
      end
      idle_inputs();
      checks++; if (bcnt !== 4'd15 || mcnt !== 4'd15) begin errors++; $display("FAIL sat_counts got=%0d/%0d exp=15/15", bcnt, mcnt); end
      rst = 1; tick(); rst = 0;
      checks++; if (bcnt !== 0 || mcnt !== 0) begin errors++; $display("FAIL sat_reset got=%0d/%0d exp=0/0", bcnt, mcnt); end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 400; i++) begin
         rst    = ($urandom_range(99) == 0);
         flush  = ($urandom_range(15) == 0);
         padv   = $urandom_range(1);
         op_bf  = $urandom_range(1);
         op_bnf = $urandom_range(1);
         pred   = $urandom_range(1);
         fv     = $urandom_range(1);
         flag   = $urandom_range(1);
         pc     = {$urandom()} & 32'hFFFF_FFFC;
         tgt    = {$urandom()} & 32'hFFFF_FFFC;
         #1;
         checks++; if (stall !== exp_stall()) begin errors++; $display("FAIL rnd_stall cyc=%0d got=%0b exp=%0b", i, stall, exp_stall()); end
         tick();
         checks++; if (pending !== m_pend) begin errors++; $display("FAIL rnd_pending cyc=%0d got=%0b exp=%0b", i, pending, m_pend); end
         checks++; if (mispredict !== e_mis) begin errors++; $display("FAIL rnd_mis cyc=%0d got=%0b exp=%0b", i, mispredict, e_mis); end
         if (e_mis) begin
            checks++; if (redirect !== e_red) begin errors++; $display("FAIL rnd_redirect cyc=%0d got=%0h exp=%0h", i, redirect, e_red); end
         end
         checks++; if (rtaken !== e_rt) begin errors++; $display("FAIL rnd_taken cyc=%0d got=%0b exp=%0b", i, rtaken, e_rt); end
         checks++; if (bcnt !== SW'(e_bc) || mcnt !== SW'(e_mc)) begin errors++; $display("FAIL rnd_counts cyc=%0d got=%0d/%0d exp=%0d/%0d", i, bcnt, mcnt, e_bc, e_mc); end
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_correct_predict();
      test_bnf_mispredict();
      test_bf_mispredict();
      test_pc_wrap();
      test_back_to_back();
      test_flush();
      test_saturation();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
